iot_riscv_writeback: RTL and testbench
======================================

IOT_RISCV_WRITEBACK -- requirements
Module: iot_riscv_writeback

Interface
REQ-001 SHALL have parameter TMO_W, default 8, width of the load-response timeout counter.
REQ-002 SHALL have parameter TMO_MAX, default 255, maximum number of cycles spent in LOAD_WAIT before a fault.
REQ-003 main_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 main_rst_an_i  in  1  reset, synchronous, active-low.
REQ-005 ex_valid_i  in  1  EX-stage result valid.
REQ-006 ex_ready_o  out  1  writeback can accept an EX result this cycle.
REQ-007 ex_rd_index_i  in  5  destination register index.
REQ-008 ex_result_i  in  32  ALU/CSR result; ignored for loads.
REQ-009 ex_is_load_i  in  1  result comes from the data bus.
REQ-010 ex_load_size_i  in  2  00 byte, 01 half, 10 word.
REQ-011 ex_load_unsigned_i  in  1  zero-extend instead of sign-extend.
REQ-012 ex_addr_lo_i  in  2  load address bits [1:0], used for lane select.
REQ-013 dbus_rvalid_i / dbus_rdata_i / dbus_err_i  in  1/32/1  data-bus read response.
REQ-014 flush_i  in  1  pipeline flush from the trap/branch unit.
REQ-015 rd_index_o / rd_value_o / rd_we_o  out  5/32/1  register-file write port.
REQ-016 id_ra_index_i / id_rb_index_i  in  5/5  decode-stage source indices.
REQ-017 fwd_data_o / fwd_a_en_o / fwd_b_en_o  out  32/1/1  forwarding to the register-file read port.
REQ-018 load_use_stall_o  out  1  decode stalls on a pending-load hazard.
REQ-019 load_fault_o  out  1  one-cycle pulse on bus error or timeout.

Function
REQ-020 SHALL implement the states IDLE, WRITE and LOAD_WAIT.
REQ-021 ex_ready_o SHALL be 1 in IDLE and WRITE and 0 in LOAD_WAIT.
REQ-022 Accept SHALL mean ex_valid_i & ex_ready_o & ~flush_i; flush_i suppresses the accept only.
REQ-023 Non-load accept SHALL register index and result, enter WRITE, and drive rd_we_o=1 for exactly the following cycle.
REQ-024 WRITE with a new accept SHALL stay in or transition per the new instruction (back-to-back, one write per cycle); without one, SHALL return to IDLE.
REQ-025 Load accept SHALL register index, size, sign and addr_lo, clear the timeout counter, and enter LOAD_WAIT; rd_we_o=0 meanwhile.
REQ-026 LOAD_WAIT with dbus_rvalid_i & ~dbus_err_i SHALL align and extend the data and enter WRITE (write one cycle after rvalid).
REQ-027 Alignment: byte = rdata[8*addr_lo+:8]; half = rdata[16*addr_lo[1]+:16]; word = rdata; sign-extend from the top bit unless unsigned; size 11 is treated as word.
REQ-028 dbus_rvalid_i & dbus_err_i, or the counter reaching TMO_MAX, SHALL pulse load_fault_o, perform no write, and enter IDLE.
REQ-029 flush_i SHALL NOT cancel a load already in LOAD_WAIT or a registered write (older instruction).
REQ-030 rd_we_o SHALL be forced to 0 when rd_index_o==0.
REQ-031 fwd_data_o SHALL equal rd_value_o.
REQ-032 fwd_a_en_o SHALL equal rd_we_o & (rd_index_o!=0) & (rd_index_o==id_ra_index_i); fwd_b_en_o likewise with id_rb_index_i.
REQ-033 load_use_stall_o SHALL be combinational: LOAD_WAIT & pending index!=0 & it matches ra or rb.
REQ-034 dbus_rvalid_i outside LOAD_WAIT SHALL be ignored.

Reset
REQ-035 While main_rst_an_i=0 at a clock edge: state IDLE, rd_we_o=0, rd_index_o=0, rd_value_o=0, counter=0, load_fault_o=0.
REQ-036 Reset in LOAD_WAIT SHALL abandon the load; a later rvalid is ignored per REQ-034.

Structure
REQ-037 The state enum and load-size encodings SHALL reside in the shared package iot_riscv_pkg.
REQ-038 Load alignment/extension SHALL be a combinational sub-module iot_riscv_load_align.

Verification
REQ-039 ALU result x5=0x1234_5678 accepted -> next cycle rd_we_o=1, rd_index_o=5, rd_value_o=0x1234_5678, fwd_a_en_o=1 when id_ra_index_i=5.
REQ-040 LB signed, addr_lo=3, rdata=0x80xx_xxxx, rd=7 -> write 0xFFFF_FF80; LHU addr_lo=2, rdata=0xBEEF_0000 -> 0x0000_BEEF.
REQ-041 Load to x9 pending, id_rb_index_i=9 -> load_use_stall_o=1, ex_ready_o=0 until rvalid; stall clears on the rvalid cycle.
REQ-042 Load with no response for 255 cycles -> load_fault_o pulses once, no write, IDLE.
REQ-043 Write to x0 -> rd_we_o=0 and no forwarding; dbus_err_i response -> fault, no write.
REQ-044 Reset asserted in LOAD_WAIT, rvalid arrives after release -> no write, state IDLE.

Source files
------------

// File: rtl/iot_riscv_pkg.sv
// Shared writeback types: FSM state, load-size encoding and the captured load context.
package iot_riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_LOAD_WAIT = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    LS_BYTE     = 2'b00,
    LS_HALF     = 2'b01,
    LS_WORD     = 2'b10,
    LS_WORD_ALT = 2'b11
  } load_size_e;

  typedef struct packed {
    load_size_e size;
    logic       is_unsigned;
    logic [1:0] addr_lo;
  } ld_ctx_t;

endpackage

// File: rtl/iot_riscv_load_align.sv
// Combinational load-data lane select and sign/zero extension; no latency, no flow control.
module iot_riscv_load_align
  import iot_riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  load_size_e  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_w = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      LS_BYTE: data_o = {{24{byte_w[7] & ~unsigned_i}}, byte_w};
      LS_HALF: data_o = {{16{half_w[15] & ~unsigned_i}}, half_w};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/iot_riscv_writeback.sv
// Writeback stage: one register-file write per cycle, one cycle after accept or load response.
// Backpressure: ex_ready_o drops while a load waits for the data bus; a timeout or bus error aborts it.
module iot_riscv_writeback
  import iot_riscv_pkg::*;
#(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic        main_clk_i,
  input  logic        main_rst_an_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  ex_rd_index_i,
  input  logic [31:0] ex_result_i,
  input  logic        ex_is_load_i,
  input  logic [1:0]  ex_load_size_i,
  input  logic        ex_load_unsigned_i,
  input  logic [1:0]  ex_addr_lo_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_err_i,
  input  logic        flush_i,
  output logic [4:0]  rd_index_o,
  output logic [31:0] rd_value_o,
  output logic        rd_we_o,
  input  logic [4:0]  id_ra_index_i,
  input  logic [4:0]  id_rb_index_i,
  output logic [31:0] fwd_data_o,
  output logic        fwd_a_en_o,
  output logic        fwd_b_en_o,
  output logic        load_use_stall_o,
  output logic        load_fault_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX);

  wb_state_e         state_q;
  logic [4:0]        rd_index_q;
  logic [31:0]       rd_value_q;
  logic              rd_we_q;
  logic              fault_q;
  ld_ctx_t           ld_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_d;
  logic              tmo_expire;
  logic              accept;
  logic [31:0]       ld_data;

  assign ex_ready_o = (state_q != ST_LOAD_WAIT);
  assign accept     = ex_valid_i & ex_ready_o & ~flush_i;
  assign tmo_d      = tmo_q + 1'b1;
  assign tmo_expire = (tmo_d == TMO_LAST);

  iot_riscv_load_align u_align (
    .rdata_i    (dbus_rdata_i),
    .size_i     (ld_q.size),
    .unsigned_i (ld_q.is_unsigned),
    .addr_lo_i  (ld_q.addr_lo),
    .data_o     (ld_data)
  );

  // rd_we_q is only ever set for a non-zero destination, so x0 never writes.
  always_ff @(posedge main_clk_i) begin
    if (!main_rst_an_i) begin
      state_q    <= ST_IDLE;
      rd_index_q <= '0;
      rd_value_q <= '0;
      rd_we_q    <= 1'b0;
      fault_q    <= 1'b0;
      ld_q       <= '0;
      tmo_q      <= '0;
    end else begin
      fault_q <= 1'b0;
      rd_we_q <= 1'b0;
      case (state_q)
        ST_LOAD_WAIT: begin
          if (dbus_rvalid_i && !dbus_err_i) begin
            rd_value_q <= ld_data;
            rd_we_q    <= (rd_index_q != 5'd0);
            state_q    <= ST_WRITE;
          end else if (dbus_rvalid_i || tmo_expire) begin
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        default: begin
          if (accept) begin
            rd_index_q <= ex_rd_index_i;
            if (ex_is_load_i) begin
              ld_q    <= '{size: load_size_e'(ex_load_size_i),
                           is_unsigned: ex_load_unsigned_i,
                           addr_lo: ex_addr_lo_i};
              tmo_q   <= '0;
              state_q <= ST_LOAD_WAIT;
            end else begin
              rd_value_q <= ex_result_i;
              rd_we_q    <= (ex_rd_index_i != 5'd0);
              state_q    <= ST_WRITE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign rd_index_o   = rd_index_q;
  assign rd_value_o   = rd_value_q;
  assign rd_we_o      = rd_we_q;
  assign load_fault_o = fault_q;
  assign fwd_data_o   = rd_value_q;
  assign fwd_a_en_o   = rd_we_q & (rd_index_q != 5'd0) & (rd_index_q == id_ra_index_i);
  assign fwd_b_en_o   = rd_we_q & (rd_index_q != 5'd0) & (rd_index_q == id_rb_index_i);
  assign load_use_stall_o = (state_q == ST_LOAD_WAIT) & (rd_index_q != 5'd0) &
                            ((rd_index_q == id_ra_index_i) | (rd_index_q == id_rb_index_i));

endmodule

// File: tb/tb_iot_riscv_writeback.sv
// Scoreboard bench for iot_riscv_writeback: expected writes/faults queued at issue, popped by a monitor.
module tb_iot_riscv_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_is_load, ex_uns, flush;
  logic [4:0]  ex_rd, rd_index, id_ra, id_rb;
  logic [31:0] ex_result, dbus_rdata, rd_value, fwd_data;
  logic [1:0]  ex_size, ex_addr_lo;
  logic        dbus_rvalid, dbus_err, rd_we, fwd_a_en, fwd_b_en, stall, fault;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } wr_t;

  wr_t exp_q[$];
  int  exp_faults = 0;
  int  n_chk = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  iot_riscv_writeback #(.TMO_W(8), .TMO_MAX(255)) dut (
    .main_clk_i         (clk),
    .main_rst_an_i      (rst_n),
    .ex_valid_i         (ex_valid),
    .ex_ready_o         (ex_ready),
    .ex_rd_index_i      (ex_rd),
    .ex_result_i        (ex_result),
    .ex_is_load_i       (ex_is_load),
    .ex_load_size_i     (ex_size),
    .ex_load_unsigned_i (ex_uns),
    .ex_addr_lo_i       (ex_addr_lo),
    .dbus_rvalid_i      (dbus_rvalid),
    .dbus_rdata_i       (dbus_rdata),
    .dbus_err_i         (dbus_err),
    .flush_i            (flush),
    .rd_index_o         (rd_index),
    .rd_value_o         (rd_value),
    .rd_we_o            (rd_we),
    .id_ra_index_i      (id_ra),
    .id_rb_index_i      (id_rb),
    .fwd_data_o         (fwd_data),
    .fwd_a_en_o         (fwd_a_en),
    .fwd_b_en_o         (fwd_b_en),
    .load_use_stall_o   (stall),
    .load_fault_o       (fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every fault pulse must match something the stimulus queued.
  always @(negedge clk) begin
    wr_t e;
    if (rd_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write", rd_index, rd_value);
      end else begin
        e = exp_q.pop_front();
        chk("wr_idx", {27'd0, rd_index}, {27'd0, e.idx});
        chk("wr_val", rd_value, e.val);
      end
    end
    if (fault === 1'b1) begin
      n_chk++;
      if (exp_faults == 0) begin
        n_err++;
        $display("FAIL unexpected_fault: got pulse expected none");
      end else begin
        exp_faults--;
      end
    end
  end

  task automatic send_alu(input logic [4:0] idx, input logic [31:0] val, input bit expect_wr);
    ex_valid   = 1'b1;
    ex_is_load = 1'b0;
    ex_rd      = idx;
    ex_result  = val;
    if (expect_wr) exp_q.push_back('{idx: idx, val: val});
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] idx, input logic [1:0] size, input logic uns,
                            input logic [1:0] addr);
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = idx;
    ex_result  = 32'hDEAD_BEEF;
    ex_size    = size;
    ex_uns     = uns;
    ex_addr_lo = addr;
    tick();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    chk("ld_ready_low", {31'd0, ex_ready}, 32'd0);
  endtask

  task automatic finish_load(input logic [4:0] idx, input logic [31:0] rdata, input logic [31:0] expv);
    dbus_rvalid = 1'b1;
    dbus_rdata  = rdata;
    exp_q.push_back('{idx: idx, val: expv});
    tick();
    dbus_rvalid = 1'b0;
    chk("ld_we", {31'd0, rd_we}, 32'd1);
    chk("ld_ready_back", {31'd0, ex_ready}, 32'd1);
  endtask

  // Load with junk EX traffic (flushed and unflushed) while waiting; none of it may be accepted.
  task automatic do_load(input logic [4:0] idx, input logic [1:0] size, input logic uns,
                         input logic [1:0] addr, input logic [31:0] rdata,
                         input logic [31:0] expv, input int wait_n);
    start_load(idx, size, uns, addr);
    for (int i = 0; i < wait_n; i++) begin
      ex_valid  = 1'b1;
      flush     = i[0];
      ex_rd     = 5'd11;
      ex_result = 32'h0BAD_0BAD;
      tick();
      chk("wait_ready", {31'd0, ex_ready}, 32'd0);
      chk("wait_we", {31'd0, rd_we}, 32'd0);
    end
    ex_valid = 1'b0;
    flush    = 1'b0;
    finish_load(idx, rdata, expv);
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_uns = 1'b0; flush = 1'b0;
    ex_rd = '0; ex_result = '0; ex_size = '0; ex_addr_lo = '0;
    dbus_rvalid = 1'b0; dbus_rdata = '0; dbus_err = 1'b0; id_ra = '0; id_rb = '0;
    repeat (3) tick();
    chk("rst_we", {31'd0, rd_we}, 32'd0);
    chk("rst_idx", {27'd0, rd_index}, 32'd0);
    chk("rst_val", rd_value, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    rst_n = 1'b1;

    // ALU write with forwarding to port A
    id_ra = 5'd5;
    send_alu(5'd5, 32'h1234_5678, 1'b1);
    chk("alu_we", {31'd0, rd_we}, 32'd1);
    chk("alu_idx", {27'd0, rd_index}, 32'd5);
    chk("alu_val", rd_value, 32'h1234_5678);
    chk("fwd_a", {31'd0, fwd_a_en}, 32'd1);
    chk("fwd_b", {31'd0, fwd_b_en}, 32'd0);
    chk("fwd_data", fwd_data, 32'h1234_5678);
    tick();
    chk("alu_we_drop", {31'd0, rd_we}, 32'd0);

    // Back-to-back writes, then a flushed instruction that must not be accepted
    id_rb = 5'd2;
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd1; ex_result = 32'h0000_000A;
    exp_q.push_back('{idx: 5'd1, val: 32'h0000_000A});
    tick();
    ex_rd = 5'd2; ex_result = 32'h0000_000B;
    exp_q.push_back('{idx: 5'd2, val: 32'h0000_000B});
    chk("b2b_idx1", {27'd0, rd_index}, 32'd1);
    tick();
    chk("b2b_idx2", {27'd0, rd_index}, 32'd2);
    chk("b2b_fwd_b", {31'd0, fwd_b_en}, 32'd1);
    flush = 1'b1; ex_rd = 5'd3; ex_result = 32'h0000_000C;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    chk("flush_no_we", {31'd0, rd_we}, 32'd0);

    // Write to x0 neither writes nor forwards
    id_ra = 5'd0; id_rb = 5'd0;
    send_alu(5'd0, 32'hDEAD_0000, 1'b0);
    chk("x0_we", {31'd0, rd_we}, 32'd0);
    chk("x0_fwd_a", {31'd0, fwd_a_en}, 32'd0);

    // Stray rvalid while idle is ignored
    tick();
    dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    tick();
    dbus_rvalid = 1'b0;
    chk("stray_rvalid_we", {31'd0, rd_we}, 32'd0);
    chk("stray_rvalid_ready", {31'd0, ex_ready}, 32'd1);

    // Alignment and extension vectors
    id_rb = 5'd9;
    do_load(5'd7,  2'b00, 1'b0, 2'd3, 32'h8012_3456, 32'hFFFF_FF80, 2);
    do_load(5'd8,  2'b01, 1'b1, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF, 0);
    do_load(5'd10, 2'b11, 1'b0, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    do_load(5'd15, 2'b01, 1'b0, 2'd0, 32'h1234_8001, 32'hFFFF_8001, 0);
    do_load(5'd16, 2'b00, 1'b1, 2'd1, 32'h0000_AB00, 32'h0000_00AB, 0);
    do_load(5'd17, 2'b01, 1'b0, 2'd3, 32'h9ABC_0000, 32'hFFFF_9ABC, 0);
    do_load(5'd18, 2'b00, 1'b0, 2'd0, 32'hFFFF_FF7F, 32'h0000_007F, 0);
    do_load(5'd19, 2'b10, 1'b1, 2'd2, 32'h8765_4321, 32'h8765_4321, 0);

    // Load-use hazard on port B
    start_load(5'd9, 2'b10, 1'b0, 2'd0);
    chk("stall_hit", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {31'd0, stall}, 32'd1);
      chk("stall_ready", {31'd0, ex_ready}, 32'd0);
    end
    finish_load(5'd9, 32'h0000_1111, 32'h0000_1111);
    chk("stall_clear", {31'd0, stall}, 32'd0);
    chk("stall_fwd_b", {31'd0, fwd_b_en}, 32'd1);
    tick();

    // Non-matching pending load does not stall
    start_load(5'd20, 2'b10, 1'b0, 2'd0);
    chk("stall_miss", {31'd0, stall}, 32'd0);
    finish_load(5'd20, 32'h2020_2020, 32'h2020_2020);
    tick();

    // Bus error
    start_load(5'd12, 2'b10, 1'b0, 2'd0);
    dbus_rvalid = 1'b1; dbus_err = 1'b1; dbus_rdata = 32'h1234_1234;
    exp_faults++;
    tick();
    dbus_rvalid = 1'b0; dbus_err = 1'b0;
    chk("err_fault", {31'd0, fault}, 32'd1);
    chk("err_we", {31'd0, rd_we}, 32'd0);
    tick();
    chk("err_fault_pulse", {31'd0, fault}, 32'd0);
    chk("err_idle", {31'd0, ex_ready}, 32'd1);

    // Timeout after 255 cycles in LOAD_WAIT
    start_load(5'd13, 2'b10, 1'b0, 2'd0);
    exp_faults++;
    n = 0;
    while (fault !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 32'd255);
    chk("tmo_we", {31'd0, rd_we}, 32'd0);
    tick();
    chk("tmo_fault_pulse", {31'd0, fault}, 32'd0);
    chk("tmo_idle", {31'd0, ex_ready}, 32'd1);

    // Reset during LOAD_WAIT abandons the load
    id_rb = 5'd14;
    start_load(5'd14, 2'b10, 1'b0, 2'd0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_ld_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_ld_stall", {31'd0, stall}, 32'd0);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h5555_5555;
    tick();
    dbus_rvalid = 1'b0;
    chk("rst_ld_we", {31'd0, rd_we}, 32'd0);
    chk("rst_ld_idle", {31'd0, ex_ready}, 32'd1);

    repeat (3) tick();
    chk("exp_writes_left", exp_q.size(), 32'd0);
    chk("exp_faults_left", exp_faults, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
